// File: rtl/raster_pkg.sv
// Shared definitions for the triangle rasterizer.
//   SCREEN_W/SCREEN_H : default raster scanned per frame
//   COORD_W           : unsigned vertex/pixel coordinate width
//   EDGE_W            : signed edge-function width (>= 2*COORD_W+2)
//   BARY_W            : width of the ua/va/wa/a output fields
//   rast_state_e      : scan controller states
//   pixel_inside()    : inclusive inside test on the three edge values
package raster_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int COORD_W  = 10;
    localparam int EDGE_W   = 22;
    localparam int BARY_W   = 20;

    typedef enum logic [1:0] {
        IDLE,
        SETUP1,
        SETUP2,
        SCAN
    } rast_state_e;

    // A pixel is covered only by a front-facing, non-degenerate triangle,
    // and pixels exactly on an edge (E == 0) count as inside.
    function automatic logic pixel_inside(input logic area_pos,
                                          input logic e12_ge0,
                                          input logic e20_ge0,
                                          input logic e01_ge0);
        return area_pos & e12_ge0 & e20_ge0 & e01_ge0;
    endfunction

endpackage

// File: rtl/edge_stepper.sv
// Incremental evaluator for one triangle edge function.
//   clk, rst_n   : clock, asynchronous active-low reset
//   load_i       : capture init_i as both current and row-start value,
//                  and latch the per-pixel x step and per-row y step
//   step_x_i     : advance one pixel along the row (E += x step)
//   step_row_i   : wrap to the next row (row-start += y step, E = row-start)
//   init_i       : edge value at pixel (0,0)
//   xstep_i      : -(yj-yi)
//   ystep_i      : (xj-xi)
//   e_o          : edge value at the current pixel
module edge_stepper
    import raster_pkg::*;
#(
    parameter int EW = raster_pkg::EDGE_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic                 step_x_i,
    input  logic                 step_row_i,
    input  logic signed [EW-1:0] init_i,
    input  logic signed [EW-1:0] xstep_i,
    input  logic signed [EW-1:0] ystep_i,
    output logic signed [EW-1:0] e_o
);

    logic signed [EW-1:0] cur_q, cur_d;
    logic signed [EW-1:0] row_q, row_d;
    logic signed [EW-1:0] xs_q, xs_d;
    logic signed [EW-1:0] ys_q, ys_d;

    always_comb begin
        cur_d = cur_q;
        row_d = row_q;
        xs_d  = xs_q;
        ys_d  = ys_q;
        if (load_i) begin
            cur_d = init_i;
            row_d = init_i;
            xs_d  = xstep_i;
            ys_d  = ystep_i;
        end else if (step_row_i) begin
            // The next row restarts from the accumulated row-start value,
            // not from the end of the current row.
            row_d = row_q + ys_q;
            cur_d = row_q + ys_q;
        end else if (step_x_i) begin
            cur_d = cur_q + xs_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q <= '0;
            row_q <= '0;
            xs_q  <= '0;
            ys_q  <= '0;
        end else begin
            cur_q <= cur_d;
            row_q <= row_d;
            xs_q  <= xs_d;
            ys_q  <= ys_d;
        end
    end

    assign e_o = cur_q;

endmodule

// File: rtl/triangle_rasterizer.sv
// Scans a WIDTH x HEIGHT raster for one triangle and streams one record per
// pixel (raster order) with edge weights, twice-area and a visible flag.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : one-cycle request, vertices sampled when idle
//   x0,y0,x1,y1,x2,y2   : CCW vertices in y-down screen space
//   busy                : frame in progress (start accepted .. last handshake)
//   out_valid/out_ready : record handshake
//   px, py              : pixel coordinate of the record
//   ua, va, wa          : E12, E20, E01 at the pixel (zero when not visible)
//   a                   : twice triangle area (zero if degenerate/back-facing)
//   visible             : pixel inside the triangle (edges inclusive)
//   last                : record is the final pixel of the raster
//   done                : one-cycle pulse after the last handshake
module triangle_rasterizer #(
    parameter int WIDTH   = raster_pkg::SCREEN_W,
    parameter int HEIGHT  = raster_pkg::SCREEN_H,
    parameter int COORD_W = raster_pkg::COORD_W,
    parameter int EDGE_W  = raster_pkg::EDGE_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [COORD_W-1:0]            x0,
    input  logic [COORD_W-1:0]            y0,
    input  logic [COORD_W-1:0]            x1,
    input  logic [COORD_W-1:0]            y1,
    input  logic [COORD_W-1:0]            x2,
    input  logic [COORD_W-1:0]            y2,
    output logic                          busy,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [COORD_W-1:0]            px,
    output logic [COORD_W-1:0]            py,
    output logic [raster_pkg::BARY_W-1:0] ua,
    output logic [raster_pkg::BARY_W-1:0] va,
    output logic [raster_pkg::BARY_W-1:0] wa,
    output logic [raster_pkg::BARY_W-1:0] a,
    output logic                          visible,
    output logic                          last,
    output logic                          done
);

    import raster_pkg::*;

    rast_state_e state_q, state_d;

    logic [COORD_W-1:0] vx_in [3];
    logic [COORD_W-1:0] vy_in [3];
    logic [COORD_W-1:0] vx_q  [3];
    logic [COORD_W-1:0] vy_q  [3];

    // Edge k spans vertex (k+1)%3 -> (k+2)%3: index 0=E12, 1=E20, 2=E01.
    logic signed [EDGE_W-1:0] dx_w [3];
    logic signed [EDGE_W-1:0] dy_w [3];
    logic signed [EDGE_W-1:0] dx_q [3];
    logic signed [EDGE_W-1:0] dy_q [3];
    logic signed [EDGE_W-1:0] init_w [3];
    logic signed [EDGE_W-1:0] e_w [3];
    logic signed [EDGE_W-1:0] area_q, area_d;

    logic [COORD_W-1:0] px_q, px_d;
    logic [COORD_W-1:0] py_q, py_d;
    logic               done_q, done_d;

    logic scan, hs, row_end, at_last;
    logic load, step_x, step_row;
    logic area_pos, vis_w;

    assign vx_in[0] = x0;
    assign vx_in[1] = x1;
    assign vx_in[2] = x2;
    assign vy_in[0] = y0;
    assign vy_in[1] = y1;
    assign vy_in[2] = y2;

    assign scan    = (state_q == SCAN);
    assign hs      = scan && out_ready;
    assign row_end = (px_q == COORD_W'(WIDTH - 1));
    assign at_last = row_end && (py_q == COORD_W'(HEIGHT - 1));

    assign load     = (state_q == SETUP2);
    assign step_x   = hs && !row_end;
    assign step_row = hs && row_end && !at_last;

    for (genvar k = 0; k < 3; k++) begin : g_edge
        localparam int I = (k + 1) % 3;
        localparam int J = (k + 2) % 3;

        assign dx_w[k] = $signed(EDGE_W'(vx_q[J])) - $signed(EDGE_W'(vx_q[I]));
        assign dy_w[k] = $signed(EDGE_W'(vy_q[J])) - $signed(EDGE_W'(vy_q[I]));

        // E(0,0) = (xj-xi)*(0-yi) - (yj-yi)*(0-xi)
        assign init_w[k] = dy_q[k] * $signed(EDGE_W'(vx_q[I]))
                         - dx_q[k] * $signed(EDGE_W'(vy_q[I]));

        edge_stepper #(.EW(EDGE_W)) u_edge (
            .clk        (clk),
            .rst_n      (rst_n),
            .load_i     (load),
            .step_x_i   (step_x),
            .step_row_i (step_row),
            .init_i     (init_w[k]),
            .xstep_i    (-dy_q[k]),
            .ystep_i    (dx_q[k]),
            .e_o        (e_w[k])
        );
    end

    // E01(x2,y2) rewritten with the registered E20 differences:
    // (x1-x0)*(y2-y0) - (y1-y0)*(x2-x0), where (x2-x0) = -dx20, (y2-y0) = -dy20.
    always_comb begin
        area_d = area_q;
        if (state_q == SETUP2) begin
            area_d = dy_q[2] * dx_q[1] - dx_q[2] * dy_q[1];
        end
    end

    always_comb begin
        state_d = state_q;
        px_d    = px_q;
        py_d    = py_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = SETUP1;
            end
            SETUP1: state_d = SETUP2;
            SETUP2: begin
                state_d = SCAN;
                px_d    = '0;
                py_d    = '0;
            end
            SCAN: begin
                if (hs) begin
                    if (at_last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (row_end) begin
                        px_d = '0;
                        py_d = py_q + 1'b1;
                    end else begin
                        px_d = px_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            px_q    <= '0;
            py_q    <= '0;
            done_q  <= 1'b0;
            area_q  <= '0;
            for (int k = 0; k < 3; k++) begin
                vx_q[k] <= '0;
                vy_q[k] <= '0;
                dx_q[k] <= '0;
                dy_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            px_q    <= px_d;
            py_q    <= py_d;
            done_q  <= done_d;
            area_q  <= area_d;
            // Vertices are only captured from IDLE; a start during a frame
            // leaves the triangle being scanned untouched.
            if (state_q == IDLE && start) begin
                for (int k = 0; k < 3; k++) begin
                    vx_q[k] <= vx_in[k];
                    vy_q[k] <= vy_in[k];
                end
            end
            if (state_q == SETUP1) begin
                for (int k = 0; k < 3; k++) begin
                    dx_q[k] <= dx_w[k];
                    dy_q[k] <= dy_w[k];
                end
            end
        end
    end

    // Record fields decode only registered state, so out_ready never reaches
    // out_valid or the data combinationally and fields hold during stalls.
    assign area_pos = (area_q > 0);
    assign vis_w    = scan && pixel_inside(area_pos, e_w[0] >= 0, e_w[1] >= 0, e_w[2] >= 0);

    assign busy      = (state_q != IDLE);
    assign out_valid = scan;
    assign px        = scan ? px_q : '0;
    assign py        = scan ? py_q : '0;
    assign ua        = vis_w ? e_w[0][BARY_W-1:0] : '0;
    assign va        = vis_w ? e_w[1][BARY_W-1:0] : '0;
    assign wa        = vis_w ? e_w[2][BARY_W-1:0] : '0;
    assign a         = (scan && area_pos) ? area_q[BARY_W-1:0] : '0;
    assign visible   = vis_w;
    assign last      = scan && at_last;
    assign done      = done_q;

endmodule

// File: tb/tb_triangle_rasterizer.sv
module tb_triangle_rasterizer;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int CW = 10;

    typedef struct {
        logic [CW-1:0] px, py;
        logic [19:0]   ua, va, wa, a;
        logic          vis, last;
    } rec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          out_ready = 1'b1;
    logic [CW-1:0] x0, y0, x1, y1, x2, y2;
    logic          busy, out_valid, visible, last, done;
    logic [CW-1:0] px, py;
    logic [19:0]   ua, va, wa, a;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   pops  = 0;
    bit   rnd_rdy = 1'b0;
    bit   spot_on = 1'b0;
    int   vx [3];
    int   vy [3];
    rec_t sb [$];

    triangle_rasterizer #(.WIDTH(W), .HEIGHT(H), .COORD_W(CW), .EDGE_W(22)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .px(px), .py(py), .ua(ua), .va(va), .wa(wa), .a(a),
        .visible(visible), .last(last), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference: each edge function evaluated directly at the pixel.
    function automatic rec_t model(input int x, input int y);
        rec_t r;
        int e12, e20, e01, ar;
        bit vis;
        e12 = (vx[2]-vx[1])*(y-vy[1]) - (vy[2]-vy[1])*(x-vx[1]);
        e20 = (vx[0]-vx[2])*(y-vy[2]) - (vy[0]-vy[2])*(x-vx[2]);
        e01 = (vx[1]-vx[0])*(y-vy[0]) - (vy[1]-vy[0])*(x-vx[0]);
        ar  = (vx[1]-vx[0])*(vy[2]-vy[0]) - (vy[1]-vy[0])*(vx[2]-vx[0]);
        vis = (ar > 0) && (e12 >= 0) && (e20 >= 0) && (e01 >= 0);
        r.px   = CW'(x);
        r.py   = CW'(y);
        r.ua   = vis ? 20'(e12) : 20'd0;
        r.va   = vis ? 20'(e20) : 20'd0;
        r.wa   = vis ? 20'(e01) : 20'd0;
        r.a    = (ar > 0) ? 20'(ar) : 20'd0;
        r.vis  = vis;
        r.last = (x == W-1) && (y == H-1);
        return r;
    endfunction

    task automatic set_verts(input int ax, ay, bx, by, cx, cy);
        vx[0] = ax; vy[0] = ay; vx[1] = bx; vy[1] = by; vx[2] = cx; vy[2] = cy;
        x0 = CW'(ax); y0 = CW'(ay); x1 = CW'(bx); y1 = CW'(by); x2 = CW'(cx); y2 = CW'(cy);
    endtask

    // Queue the expected frame, pulse start, and check the 3-cycle latency.
    task automatic start_frame();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                sb.push_back(model(x, y));
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("lat_c1_valid", out_valid, 0);
        chk("lat_c1_busy", busy, 1);
        @(negedge clk);
        chk("lat_c2_valid", out_valid, 0);
        @(negedge clk);
        chk("lat_c3_valid", out_valid, 1);
    endtask

    task automatic wait_done(input int exp_cyc);
        int  n = 0;
        bit  seen = 1'b0;
        while (!seen && n < 3000) begin
            @(negedge clk);
            n++;
            if (done) seen = 1'b1;
        end
        chk("frame_done_seen", seen, 1);
        if (exp_cyc > 0) chk("frame_cycles", n, exp_cyc);
        chk("sb_empty", sb.size(), 0);
    endtask

    task automatic wait_pops(input int n);
        int k = 0;
        while (pops < n && k < 3000) begin
            @(negedge clk); #1;
            k++;
        end
        chk("reach_record", pops >= n, 1);
    endtask

    // Ready driver: changes just after the rising edge.
    initial begin
        forever begin
            @(posedge clk); #1;
            out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor / scoreboard.
    initial begin : mon
        rec_t e, held;
        bit   stalled = 1'b0;
        bit   exp_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled  = 1'b0;
                exp_done = 1'b0;
            end else begin
                chk("done_pulse", done, exp_done);
                if (exp_done) begin
                    chk("end_busy", busy, 0);
                    chk("end_valid", out_valid, 0);
                end
                exp_done = 1'b0;
                if (stalled) begin
                    chk("stall_valid", out_valid, 1);
                    chk("stall_px", px, held.px);
                    chk("stall_py", py, held.py);
                    chk("stall_ua", ua, held.ua);
                    chk("stall_va", va, held.va);
                    chk("stall_wa", wa, held.wa);
                    chk("stall_a", a, held.a);
                    chk("stall_vis", visible, held.vis);
                    chk("stall_last", last, held.last);
                end
                stalled = 1'b0;
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_record", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk($sformatf("rec%0d.px", pops), px, e.px);
                        chk($sformatf("rec%0d.py", pops), py, e.py);
                        chk($sformatf("rec%0d.ua", pops), ua, e.ua);
                        chk($sformatf("rec%0d.va", pops), va, e.va);
                        chk($sformatf("rec%0d.wa", pops), wa, e.wa);
                        chk($sformatf("rec%0d.a", pops), a, e.a);
                        chk($sformatf("rec%0d.vis", pops), visible, e.vis);
                        chk($sformatf("rec%0d.last", pops), last, e.last);
                        if (spot_on) begin
                            if (px == 1 && py == 1) begin
                                chk("spot11_ua", ua, 8);  chk("spot11_va", va, 4);
                                chk("spot11_wa", wa, 4);  chk("spot11_a", a, 16);
                                chk("spot11_vis", visible, 1);
                            end
                            if (px == 4 && py == 4) begin
                                chk("spot44_vis", visible, 0); chk("spot44_ua", ua, 0);
                                chk("spot44_va", va, 0);       chk("spot44_wa", wa, 0);
                            end
                            if (px == 0 && py == 0) begin
                                chk("spot00_ua", ua, 16); chk("spot00_va", va, 0);
                                chk("spot00_wa", wa, 0);  chk("spot00_vis", visible, 1);
                            end
                            if (px == 2 && py == 0) chk("spot20_vis", visible, 1);
                        end
                        pops++;
                        if (e.last) exp_done = 1'b1;
                    end
                end else if (out_valid) begin
                    stalled   = 1'b1;
                    held.px   = px;  held.py = py;
                    held.ua   = ua;  held.va = va;  held.wa = wa;  held.a = a;
                    held.vis  = visible;
                    held.last = last;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set_verts(0, 0, 4, 0, 0, 4);
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_px", px, 0);
        chk("rst_ua", ua, 0);
        chk("rst_a", a, 0);
        @(negedge clk); rst_n = 1'b1;

        // Frame 1: CCW triangle, always ready -> 64 records in 64 cycles.
        spot_on = 1'b1;
        start_frame();
        wait_done(64);

        // Frame 2: same triangle with random back-pressure.
        rnd_rdy = 1'b1;
        start_frame();
        wait_done(0);
        rnd_rdy = 1'b0;
        spot_on = 1'b0;

        // Frame 3: clockwise -> nothing visible, a=0.
        set_verts(0, 0, 0, 4, 4, 0);
        start_frame();
        wait_done(64);

        // Frame 4: start during scan is ignored.
        set_verts(0, 0, 4, 0, 0, 4);
        start_frame();
        wait_pops(pops + 10);
        x0 = 10'd1; y0 = 10'd1; x1 = 10'd6; y1 = 10'd1; x2 = 10'd1; y2 = 10'd6;
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        set_verts(0, 0, 4, 0, 0, 4);
        chk("restart_busy", busy, 1);
        wait_done(0);

        // Frame 5: async reset mid-frame, then a fresh full frame.
        start_frame();
        wait_pops(pops + 20);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_px", px, 0);
        chk("arst_py", py, 0);
        chk("arst_ua", ua, 0);
        chk("arst_a", a, 0);
        chk("arst_vis", visible, 0);
        chk("arst_last", last, 0);
        sb.delete();
        @(negedge clk); #1;
        rst_n = 1'b1;
        spot_on = 1'b1;
        start_frame();
        wait_done(64);
        spot_on = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
